decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered successor to the combinational main decoder; sits between the IF/ID register and EX.
- Decodes one 32-bit MIPS instruction per cycle into a registered control word with a valid/ready handshake.
- Adds MULT/MULTU/DIV/DIVU, BNE, ADDIU, SLTI, SLTIU, JAL and an illegal-instruction flag.
- Tracks HI/LO occupancy with a parametrised latency counter and stalls hazarding HI/LO instructions.

Parameters:
- MUL_CYCLES, 1: cycles HI/LO stays busy after a MULT/MULTU leaves this stage; must be >= 1.
- DIV_CYCLES, 36: cycles HI/LO stays busy after a DIV/DIVU leaves this stage; must be >= MUL_CYCLES.
- ENABLE_MULDIV, 1: 0 decodes MULT/MULTU/DIV/DIVU as illegal and ties the counter to zero.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr  in  32  instruction from IF/ID
- instr_valid  in  1  instr is valid
- instr_ready  out  1  stage accepts instr this cycle
- flush  in  1  kill held and incoming instruction
- ex_ready  in  1  EX accepts the control word
- ctrl_valid  out  1  control word valid
- regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump  out  1 each  classic controls
- hilo_write, hi_to_reg, lo_to_reg  out  1 each  HI/LO controls
- zero_ext  out  1  logical immediate; 1 iff op[5:2]==4'b0011
- branch_ne  out  1  BNE (branch also 1)
- link  out  1  JAL: write PC+8 to r31
- muldiv_start  out  1  MULT/MULTU/DIV/DIVU
- muldiv_op  out  2  funct[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- illegal  out  1  unsupported opcode/funct
- hilo_busy  out  1  HI/LO result pending

Behaviour:
- Reset: ctrl_valid=0, all control outputs 0, counter=0, hilo_busy=0.
- Latency: 1 cycle. A word transfers in when instr_valid && instr_ready and is visible on the outputs the next cycle.
- Outputs hold while ctrl_valid && !ex_ready.
- instr_ready = (!ctrl_valid || ex_ready) && !stall && !flush.
- uses_hilo: R-type with funct MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- hilo_busy = (counter != 0) || (ctrl_valid && muldiv_start).
- stall = instr_valid && uses_hilo && hilo_busy.
- Handoff = ctrl_valid && ex_ready && !flush.
  - On handoff of MULT/MULTU: counter loads MUL_CYCLES.
  - On handoff of DIV/DIVU: counter loads DIV_CYCLES.
  - Otherwise the counter decrements while nonzero and saturates at 0.
- Flush has priority:
  - Next cycle ctrl_valid=0.
  - A same-cycle handoff does not count and does not load the counter.
  - An incoming instruction is dropped.
  - A counter already running keeps counting, since the op was already in EX.
- Illegal decode: all controls 0, illegal=1, ctrl_valid=1. The word still flows downstream for exception handling.
- Control vector {regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump,hilo_write,hi_to_reg,lo_to_reg}:
  - R ALU (AND/OR/XOR/NOR/shifts/ADD/ADDU/SUB/SUBU/SLT/SLTU): 1100000000
  - MFHI: 1100000010
  - MFLO: 1100000001
  - MTHI, MTLO, MULT, MULTU, DIV, DIVU: 0000000100
  - ANDI/ORI/XORI/LUI/ADDI/ADDIU/SLTI/SLTIU: 1010000000
  - LW: 1010010000
  - SW: 0010100000
  - BEQ: 0001000000
  - BNE: 0001000000 plus branch_ne=1
  - J: 0000001000
  - JAL: 1000001000 plus link=1
- Decode is combinational from instr and is registered only on accept. No state other than the output register and the counter.
- Counter width: $clog2(DIV_CYCLES+1).

Decomposition:
- Shared package/header: opcode and funct constants, including new MULT/DIV/BNE/ADDIU/SLTI/SLTIU/JAL entries, and the control-vector bit positions.
- One sub-module, decode_comb: pure combinational instr -> control vector, plus illegal, uses_hilo and muldiv flags.
- decode_stage adds the register, handshake and hilo counter.

Test Plan:
- Reset, then ADDI 0x20010005 with ex_ready=1 -> next cycle ctrl_valid=1, regwrite=1, alusrc=1, zero_ext=0, all other controls 0.
- DIV (funct 0x1A) handed off, then MFLO offered immediately, DIV_CYCLES=4 -> instr_ready=0 for 4 cycles, MFLO accepted in cycle 5 with lo_to_reg=1.
- MULT held with ex_ready=0 and MFHI offered -> stall held until handoff; counter loads 1; MFHI accepted one cycle later.
- flush asserted with DIV valid and ex_ready=1 -> ctrl_valid=0 next cycle, counter stays 0, hilo_busy=0.
- Opcode 0x3F, and MULT with ENABLE_MULDIV=0 -> illegal=1, all controls 0, ctrl_valid=1.
- Back-to-back LW, SW, BNE, JAL with ex_ready toggling 1,0,1 -> no loss or duplication; BNE gives branch=1, branch_ne=1; JAL gives regwrite=1, jump=1, link=1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared opcode/funct encodings and control-word layout for the decode stage.
package decode_stage_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   localparam int CV_W          = 10;
   localparam int CV_REGWRITE   = 9;
   localparam int CV_REGDST     = 8;
   localparam int CV_ALUSRC     = 7;
   localparam int CV_BRANCH     = 6;
   localparam int CV_MEMWRITE   = 5;
   localparam int CV_MEMTOREG   = 4;
   localparam int CV_JUMP       = 3;
   localparam int CV_HILO_WRITE = 2;
   localparam int CV_HI_TO_REG  = 1;
   localparam int CV_LO_TO_REG  = 0;

   typedef struct packed {
      logic [CV_W-1:0] cv;
      logic            zero_ext;
      logic            branch_ne;
      logic            link;
      logic            muldiv_start;
      logic [1:0]      muldiv_op;
      logic            illegal;
   } ctrl_t;

   function automatic logic is_hilo_funct(input logic [5:0] fn);
      return fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
   endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Pure combinational MIPS main decoder: instruction -> control word.
module decode_comb
   import decode_stage_pkg::*;
#(
   parameter bit ENABLE_MULDIV = 1'b1
) (
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic        uses_hilo
);

   logic [5:0] op;
   logic [5:0] fn;
   logic       unused_fields;

   assign op            = instr[31:26];
   assign fn            = instr[5:0];
   assign unused_fields = ^instr[25:6];

   always_comb begin
      ctrl = '0;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
               FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
               FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                  ctrl.cv[CV_REGWRITE] = 1'b1;
                  ctrl.cv[CV_REGDST]   = 1'b1;
               end
               FN_MFHI: begin
                  ctrl.cv[CV_REGWRITE]  = 1'b1;
                  ctrl.cv[CV_REGDST]    = 1'b1;
                  ctrl.cv[CV_HI_TO_REG] = 1'b1;
               end
               FN_MFLO: begin
                  ctrl.cv[CV_REGWRITE]  = 1'b1;
                  ctrl.cv[CV_REGDST]    = 1'b1;
                  ctrl.cv[CV_LO_TO_REG] = 1'b1;
               end
               FN_MTHI, FN_MTLO: ctrl.cv[CV_HILO_WRITE] = 1'b1;
               FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                  if (ENABLE_MULDIV) begin
                     ctrl.cv[CV_HILO_WRITE] = 1'b1;
                     ctrl.muldiv_start      = 1'b1;
                     ctrl.muldiv_op         = fn[1:0];
                  end else begin
                     ctrl.illegal = 1'b1;
                  end
               end
               default: ctrl.illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            ctrl.cv[CV_REGWRITE] = 1'b1;
            ctrl.cv[CV_ALUSRC]   = 1'b1;
            ctrl.zero_ext        = (op[5:2] == 4'b0011);
         end
         OP_LW: begin
            ctrl.cv[CV_REGWRITE] = 1'b1;
            ctrl.cv[CV_ALUSRC]   = 1'b1;
            ctrl.cv[CV_MEMTOREG] = 1'b1;
         end
         OP_SW: begin
            ctrl.cv[CV_ALUSRC]   = 1'b1;
            ctrl.cv[CV_MEMWRITE] = 1'b1;
         end
         OP_BEQ: ctrl.cv[CV_BRANCH] = 1'b1;
         OP_BNE: begin
            ctrl.cv[CV_BRANCH] = 1'b1;
            ctrl.branch_ne     = 1'b1;
         end
         OP_J: ctrl.cv[CV_JUMP] = 1'b1;
         OP_JAL: begin
            ctrl.cv[CV_REGWRITE] = 1'b1;
            ctrl.cv[CV_JUMP]     = 1'b1;
            ctrl.link            = 1'b1;
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end

   // Hazard detection looks at the raw encoding, independent of legality.
   assign uses_hilo = (op == OP_RTYPE) && is_hilo_funct(fn);

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, flush, and HI/LO busy tracking.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned MUL_CYCLES    = 1,
   parameter int unsigned DIV_CYCLES    = 36,
   parameter bit          ENABLE_MULDIV = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic        flush,
   input  logic        ex_ready,
   output logic        ctrl_valid,
   output logic        regwrite,
   output logic        regdst,
   output logic        alusrc,
   output logic        branch,
   output logic        memwrite,
   output logic        memtoreg,
   output logic        jump,
   output logic        hilo_write,
   output logic        hi_to_reg,
   output logic        lo_to_reg,
   output logic        zero_ext,
   output logic        branch_ne,
   output logic        link,
   output logic        muldiv_start,
   output logic [1:0]  muldiv_op,
   output logic        illegal,
   output logic        hilo_busy
);

   localparam int CNT_W = $clog2(DIV_CYCLES + 1);

   ctrl_t            dec_ctrl;
   logic             dec_uses_hilo;
   ctrl_t            ctrl_q, ctrl_d;
   logic             vld_q, vld_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stall, accept, handoff;

   decode_comb #(.ENABLE_MULDIV(ENABLE_MULDIV)) u_decode_comb (
      .instr     (instr),
      .ctrl      (dec_ctrl),
      .uses_hilo (dec_uses_hilo)
   );

   // A mul/div sitting in the output register already counts as busy.
   assign hilo_busy   = (cnt_q != '0) || (vld_q && ctrl_q.muldiv_start);
   assign stall       = instr_valid && dec_uses_hilo && hilo_busy;
   assign instr_ready = (!vld_q || ex_ready) && !stall && !flush;
   assign accept      = instr_valid && instr_ready;
   assign handoff     = vld_q && ex_ready && !flush;

   always_comb begin
      ctrl_d = ctrl_q;
      vld_d  = vld_q;
      cnt_d  = cnt_q;
      if (flush) begin
         vld_d  = 1'b0;
         ctrl_d = '0;
      end else if (accept) begin
         vld_d  = 1'b1;
         ctrl_d = dec_ctrl;
      end else if (handoff) begin
         vld_d  = 1'b0;
         ctrl_d = '0;
      end
      // A flushed handoff never loads, but a running count keeps going.
      if (handoff && ctrl_q.muldiv_start)
         cnt_d = ctrl_q.muldiv_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
      else if (cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
      if (!ENABLE_MULDIV)
         cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         ctrl_q <= '0;
         cnt_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         ctrl_q <= ctrl_d;
         cnt_q  <= cnt_d;
      end
   end

   assign ctrl_valid   = vld_q;
   assign regwrite     = ctrl_q.cv[CV_REGWRITE];
   assign regdst       = ctrl_q.cv[CV_REGDST];
   assign alusrc       = ctrl_q.cv[CV_ALUSRC];
   assign branch       = ctrl_q.cv[CV_BRANCH];
   assign memwrite     = ctrl_q.cv[CV_MEMWRITE];
   assign memtoreg     = ctrl_q.cv[CV_MEMTOREG];
   assign jump         = ctrl_q.cv[CV_JUMP];
   assign hilo_write   = ctrl_q.cv[CV_HILO_WRITE];
   assign hi_to_reg    = ctrl_q.cv[CV_HI_TO_REG];
   assign lo_to_reg    = ctrl_q.cv[CV_LO_TO_REG];
   assign zero_ext     = ctrl_q.zero_ext;
   assign branch_ne    = ctrl_q.branch_ne;
   assign link         = ctrl_q.link;
   assign muldiv_start = ctrl_q.muldiv_start;
   assign muldiv_op    = ctrl_q.muldiv_op;
   assign illegal      = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized checks of decode_stage against a cycle-level reference model.
module tb_decode_stage;

   localparam int MUL_C = 1;
   localparam int DIV_C = 4;

   logic        clk, rst, instr_valid, flush, ex_ready;
   logic [31:0] instr;

   logic        instr_ready, ctrl_valid, hilo_busy;
   logic        regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump;
   logic        hilo_write, hi_to_reg, lo_to_reg, zero_ext, branch_ne, link;
   logic        muldiv_start, illegal;
   logic [1:0]  muldiv_op;

   logic        nm_ready, nm_valid, nm_busy;
   logic        nm_rw, nm_rd, nm_as, nm_br, nm_mw, nm_mr, nm_j;
   logic        nm_hw, nm_h2r, nm_l2r, nm_zx, nm_bne, nm_lk, nm_ms, nm_ill;
   logic [1:0]  nm_mo;

   decode_stage #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .ENABLE_MULDIV(1'b1)) u_dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .flush(flush), .ex_ready(ex_ready),
      .ctrl_valid(ctrl_valid), .regwrite(regwrite), .regdst(regdst), .alusrc(alusrc),
      .branch(branch), .memwrite(memwrite), .memtoreg(memtoreg), .jump(jump),
      .hilo_write(hilo_write), .hi_to_reg(hi_to_reg), .lo_to_reg(lo_to_reg),
      .zero_ext(zero_ext), .branch_ne(branch_ne), .link(link),
      .muldiv_start(muldiv_start), .muldiv_op(muldiv_op), .illegal(illegal),
      .hilo_busy(hilo_busy)
   );

   decode_stage #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .ENABLE_MULDIV(1'b0)) u_nm (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(nm_ready), .flush(flush), .ex_ready(ex_ready),
      .ctrl_valid(nm_valid), .regwrite(nm_rw), .regdst(nm_rd), .alusrc(nm_as),
      .branch(nm_br), .memwrite(nm_mw), .memtoreg(nm_mr), .jump(nm_j),
      .hilo_write(nm_hw), .hi_to_reg(nm_h2r), .lo_to_reg(nm_l2r),
      .zero_ext(nm_zx), .branch_ne(nm_bne), .link(nm_lk),
      .muldiv_start(nm_ms), .muldiv_op(nm_mo), .illegal(nm_ill),
      .hilo_busy(nm_busy)
   );

   // Word layout: [16:7] classic+HI/LO vector, [6] zext, [5] bne, [4] link,
   // [3] muldiv_start, [2:1] muldiv_op, [0] illegal.
   logic [16:0] dut_word, nm_word;
   assign dut_word = {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump,
                      hilo_write, hi_to_reg, lo_to_reg, zero_ext, branch_ne, link,
                      muldiv_start, muldiv_op, illegal};
   assign nm_word  = {nm_rw, nm_rd, nm_as, nm_br, nm_mw, nm_mr, nm_j,
                      nm_hw, nm_h2r, nm_l2r, nm_zx, nm_bne, nm_lk,
                      nm_ms, nm_mo, nm_ill};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   bit          m_vld;
   logic [16:0] m_word;
   int          m_cnt;
   bit          last_acc;
   bit          rec;
   logic [16:0] sb[$];

   function automatic logic [16:0] ref_decode(input logic [31:0] ins, input bit en);
      logic [5:0] op, fn;
      logic [9:0] v;
      logic       zx, bne, lk, ms, ill;
      logic [1:0] mo;
      op = ins[31:26]; fn = ins[5:0];
      v = 10'b0; zx = 0; bne = 0; lk = 0; ms = 0; mo = 2'b00; ill = 0;
      if (op == 6'h00) begin
         if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                        [6'h20:6'h27], 6'h2A, 6'h2B}) v = 10'b1100000000;
         else if (fn == 6'h10) v = 10'b1100000010;
         else if (fn == 6'h12) v = 10'b1100000001;
         else if (fn == 6'h11 || fn == 6'h13) v = 10'b0000000100;
         else if (fn >= 6'h18 && fn <= 6'h1B && en) begin
            v = 10'b0000000100; ms = 1; mo = fn[1:0];
         end else ill = 1;
      end else if (op >= 6'h08 && op <= 6'h0F) begin
         v = 10'b1010000000; zx = (op >= 6'h0C);
      end else if (op == 6'h23) v = 10'b1010010000;
      else if (op == 6'h2B) v = 10'b0010100000;
      else if (op == 6'h04) v = 10'b0001000000;
      else if (op == 6'h05) begin v = 10'b0001000000; bne = 1; end
      else if (op == 6'h02) v = 10'b0000001000;
      else if (op == 6'h03) begin v = 10'b1000001000; lk = 1; end
      else ill = 1;
      return {v, zx, bne, lk, ms, mo, ill};
   endfunction

   function automatic bit ref_uses_hilo(input logic [31:0] ins);
      return ins[31:26] == 6'h00 &&
             ((ins[5:0] >= 6'h10 && ins[5:0] <= 6'h13) ||
              (ins[5:0] >= 6'h18 && ins[5:0] <= 6'h1B));
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: check combinational outputs before the edge, advance the
   // model at the edge, then check the registered outputs.
   task automatic tick();
      bit exp_rdy, exp_busy, hand, acc;
      #1;
      exp_busy = (m_cnt > 0) || (m_vld && m_word[3]);
      exp_rdy  = (!m_vld || ex_ready) &&
                 !(instr_valid && ref_uses_hilo(instr) && exp_busy) && !flush;
      chk("instr_ready", {31'b0, instr_ready}, {31'b0, exp_rdy});
      chk("hilo_busy_pre", {31'b0, hilo_busy}, {31'b0, exp_busy});
      hand = m_vld && ex_ready && !flush;
      acc  = instr_valid && exp_rdy;
      if (rec && ctrl_valid && ex_ready && !flush) sb.push_back(dut_word);
      last_acc = acc && !rst;
      @(posedge clk);
      if (rst) begin
         m_vld = 0; m_word = '0; m_cnt = 0;
      end else begin
         if (hand && m_word[3]) m_cnt = m_word[2] ? DIV_C : MUL_C;
         else if (m_cnt > 0) m_cnt--;
         if (flush) begin m_vld = 0; m_word = '0; end
         else if (acc) begin m_vld = 1; m_word = ref_decode(instr, 1'b1); end
         else if (hand) begin m_vld = 0; m_word = '0; end
      end
      #1;
      exp_busy = (m_cnt > 0) || (m_vld && m_word[3]);
      chk("ctrl_valid", {31'b0, ctrl_valid}, {31'b0, m_vld});
      chk("ctrl_word", {15'b0, dut_word}, {15'b0, m_word});
      chk("hilo_busy", {31'b0, hilo_busy}, {31'b0, exp_busy});
   endtask

   task automatic offer(input logic [31:0] ins, input int max, input bit tog);
      bit got;
      got = 0;
      instr = ins; instr_valid = 1;
      for (int i = 0; i < max && !got; i++) begin
         tick();
         got = last_acc;
         if (tog) ex_ready = ~ex_ready;
      end
      instr_valid = 0;
      chk("accept_bound", {31'b0, got}, 32'd1);
   endtask

   task automatic idle(input int n);
      instr_valid = 0; flush = 0; ex_ready = 1;
      for (int i = 0; i < n; i++) tick();
   endtask

   logic [31:0] pool [16] = '{32'h00221820, 32'h00221824, 32'h00011080, 32'h00001810,
                              32'h00001812, 32'h00200011, 32'h00200013, 32'h00220018,
                              32'h00220019, 32'h0022001A, 32'h0022001B, 32'h8C220004,
                              32'hAC220004, 32'h14220003, 32'h0C000010, 32'h3022FFFF};
   logic [31:0] seq4 [4] = '{32'h8C220004, 32'hAC220004, 32'h14220003, 32'h0C000010};

   initial begin
      logic [31:0] r;
      rst = 1; instr = '0; instr_valid = 0; flush = 0; ex_ready = 0;
      m_vld = 0; m_word = '0; m_cnt = 0; rec = 0; last_acc = 0;
      tick(); tick();
      chk("reset_valid", {31'b0, ctrl_valid}, 32'd0);
      chk("reset_word", {15'b0, dut_word}, 32'd0);
      chk("reset_busy", {31'b0, hilo_busy}, 32'd0);
      rst = 0;

      // ADDI r1,r0,5
      ex_ready = 1;
      offer(32'h20010005, 1, 0);
      chk("addi_word", {15'b0, dut_word}, {15'b0, 10'b1010000000, 7'b0});
      idle(1);

      // DIV then MFLO offered immediately
      offer(32'h0022001A, 1, 0);
      offer(32'h00001812, 12, 0);
      chk("mflo_lo_to_reg", {31'b0, lo_to_reg}, 32'd1);
      idle(6);

      // MULT held downstream with MFHI waiting behind it
      offer(32'h00220018, 1, 0);
      ex_ready = 0; instr = 32'h00001810; instr_valid = 1;
      tick(); tick(); tick();
      ex_ready = 1;
      offer(32'h00001810, 6, 0);
      chk("mfhi_hi_to_reg", {31'b0, hi_to_reg}, 32'd1);
      idle(3);

      // Flush kills a held DIV and the incoming word
      ex_ready = 0;
      offer(32'h0022001A, 1, 0);
      instr = 32'h20010005; instr_valid = 1; flush = 1; ex_ready = 1;
      tick();
      flush = 0; instr_valid = 0;
      chk("flush_valid", {31'b0, ctrl_valid}, 32'd0);
      chk("flush_busy", {31'b0, hilo_busy}, 32'd0);
      idle(2);

      // Unknown opcode
      offer(32'hFC000000, 1, 0);
      chk("illegal_word", {15'b0, dut_word}, 32'd1);
      chk("illegal_valid", {31'b0, ctrl_valid}, 32'd1);
      idle(1);

      // Back-to-back LW/SW/BNE/JAL with EX toggling readiness
      rec = 1; sb.delete();
      for (int k = 0; k < 4; k++) offer(seq4[k], 8, 1);
      idle(4);
      rec = 0;
      chk("seq_count", sb.size(), 32'd4);
      for (int k = 0; k < 4 && k < sb.size(); k++)
         chk($sformatf("seq_word%0d", k), {15'b0, sb[k]}, {15'b0, ref_decode(seq4[k], 1'b1)});

      // MULT with mul/div disabled decodes as illegal
      rst = 1; tick(); rst = 0;
      offer(32'h00220018, 1, 0);
      chk("nm_valid", {31'b0, nm_valid}, 32'd1);
      chk("nm_word", {15'b0, nm_word}, 32'd1);
      chk("nm_busy", {31'b0, nm_busy}, 32'd0);
      idle(6);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom();
         if ($urandom_range(0, 4) == 0) instr = r;
         else if (pool[r[3:0]][31:26] == 6'h00) instr = pool[r[3:0]] | ($urandom() & 32'h03FFFFC0);
         else instr = pool[r[3:0]] | ($urandom() & 32'h03FFFFFF);
         instr_valid = ($urandom_range(0, 9) < 7);
         ex_ready    = ($urandom_range(0, 9) < 7);
         flush       = ($urandom_range(0, 11) == 0);
         tick();
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
